// File: rtl/brr_pp_sched.sv
// -----------------------------------------------------------------------------
// brr_pp_sched
//   Frame-level flow controller for the bit-reversal ping-pong reorder buffer.
//   Turns the upstream/downstream valid/ready handshakes into the buffer's
//   wr_en/rd_en and keeps shadow copies of the buffer's write/read counters.
//   A bank is never overwritten while it is still being read, and banks never
//   swap while a read frame is only partially consumed.
//
//   State table:
//     FILL  | no readable bank; writer fills the write bank
//     DRAIN | read bank readable; writer fills the other bank
//     STALL | writer holding the last sample of its frame until the reader
//           | reaches the last sample of the current read frame
//
//   Optional feature macro: BRR_SCHED_STATS_EN
//     defined     -> o_stall_cnt / o_frame_cnt ports and counters present
//     not defined -> those ports and counters are absent
//
//   Ports:
//     clk           clock, rising edge
//     rst           asynchronous active-high reset (shared with the buffer)
//     i_in_valid    upstream sample available
//     o_in_ready    sample accepted this cycle
//     o_out_valid   buffer data_out holds a valid natural-order sample
//     i_out_ready   downstream consumes sample this cycle
//     o_out_sof     current output sample is index 0 of its frame
//     o_out_eof     current output sample is index DEPTH-1 of its frame
//     o_buf_wr_en   buffer write enable
//     o_buf_rd_en   buffer read enable
//     o_frame_in    1-cycle pulse after the last sample of a frame is written
//     o_frame_out   1-cycle pulse after the last sample of a frame is read
//     o_stall_cnt   (stats) cycles with i_in_valid && !o_in_ready, saturating
//     o_frame_cnt   (stats) frames fully read, saturating
// -----------------------------------------------------------------------------
module brr_pp_sched #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_out_sof,
  output logic                 o_out_eof,
  output logic                 o_buf_wr_en,
  output logic                 o_buf_rd_en,
  output logic                 o_frame_in,
  output logic                 o_frame_out
`ifdef BRR_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_stall_cnt,
  output logic [CNT_WIDTH-1:0] o_frame_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST = '1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic                  r_frame_in;
  logic                  r_frame_out;

  logic w_wr_last;
  logic w_rd_last;
  logic w_in_ready;
  logic w_out_valid;
  logic w_wr_en;
  logic w_rd_en;

  assign w_wr_last = (r_wr_cnt == LP_LAST);
  assign w_rd_last = (r_rd_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;

    case (r_state)
      S_FILL: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        // The last write of a frame may only land on the same edge that
        // retires the last read, since that write completes the bank swap.
        w_in_ready  = !w_wr_last || (i_out_ready && w_rd_last);
      end
      S_STALL: begin
        w_out_valid = 1'b1;
        w_in_ready  = i_out_ready && w_rd_last;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
      end
    endcase

    w_wr_en = i_in_valid && w_in_ready;
    w_rd_en = w_out_valid && i_out_ready;

    case (r_state)
      S_FILL: begin
        if (w_wr_en && w_wr_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd_en && w_rd_last) begin
          // Swap straight into a fresh readable frame if the writer finishes
          // on the same edge; otherwise nothing is left to read.
          if (w_wr_en && w_wr_last) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else if (i_in_valid && w_wr_last && !w_in_ready) begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (w_rd_en && w_rd_last) begin
          // Last read retired: swap if the held sample went in with it,
          // otherwise the writer withdrew and no frame remains readable.
          if (w_wr_en) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else if (!i_in_valid) begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // Shadow copies of the buffer's write/read address counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  // Frame boundary pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_in  <= 1'b0;
      r_frame_out <= 1'b0;
    end else begin
      r_frame_in  <= w_wr_en && w_wr_last;
      r_frame_out <= w_rd_en && w_rd_last;
    end
  end

`ifdef BRR_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (i_in_valid && !w_in_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_rd_en && w_rd_last && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_buf_wr_en = w_wr_en;
  assign o_buf_rd_en = w_rd_en;
  assign o_out_sof   = w_out_valid && (r_rd_cnt == '0);
  assign o_out_eof   = w_out_valid && w_rd_last;
  assign o_frame_in  = r_frame_in;
  assign o_frame_out = r_frame_out;

endmodule

// File: tb/tb_brr_pp_sched.sv
// -----------------------------------------------------------------------------
// tb_brr_pp_sched
//   Directed bench for brr_pp_sched with ADDR_WIDTH=3 (8-sample frames) and a
//   small ping-pong buffer model: writes go to address wr_cnt of the write
//   bank, reads come from address bitrev(rd_cnt) of the read bank, so a frame
//   written as 0..7 reads back as 0,4,2,6,1,5,3,7.
// -----------------------------------------------------------------------------
module tb_brr_pp_sched;

  localparam int AW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;
  logic          wr_en;
  logic          rd_en;
  logic          frame_in;
  logic          frame_out;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] frame_cnt;
  logic [7:0]    din;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brr_pp_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sof   (out_sof),
    .o_out_eof   (out_eof),
    .o_buf_wr_en (wr_en),
    .o_buf_rd_en (rd_en),
    .o_frame_in  (frame_in),
    .o_frame_out (frame_out)
`ifdef BRR_SCHED_STATS_EN
    ,
    .o_stall_cnt (stall_cnt),
    .o_frame_cnt (frame_cnt)
`endif
  );

`ifndef BRR_SCHED_STATS_EN
  assign stall_cnt = '0;
  assign frame_cnt = '0;
`endif

  // Ping-pong buffer model
  logic [7:0]    mem [16];
  logic          m_wb, m_rb;
  logic [AW-1:0] m_wc, m_rc;
  logic [7:0]    dout;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[{m_wb, m_wc}] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wb <= 1'b0; m_rb <= 1'b0; m_wc <= '0; m_rc <= '0;
    end else begin
      if (wr_en) begin
        m_wc <= m_wc + 1'b1;
        if (m_wc == 3'd7) m_wb <= ~m_wb;
      end
      if (rd_en) begin
        m_rc <= m_rc + 1'b1;
        if (m_rc == 3'd7) m_rb <= ~m_rb;
      end
    end
  end

  assign dout = mem[{m_rb, bitrev(m_rc)}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;

    // Reset state
    #3;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_en",     wr_en,     0);
    chk("rst_rd_en",     rd_en,     0);
    chk("rst_frame_in",  frame_in,  0);
    chk("rst_frame_out", frame_out, 0);
    chk("rst_sof",       out_sof,   0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // Fill one frame 0..7 with downstream held off
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 8'(i); #1;
      chk("fill_in_ready",  in_ready,  1);
      chk("fill_out_valid", out_valid, 0);
      tick();
    end
    in_valid = 1'b0; #1;
    chk("fill_latency_valid", out_valid, 1);
    chk("fill_frame_in",      frame_in,  1);

    // Drain it: bit-reversed read order
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rd0_data",  dout,    32'(bitrev(AW'(k))));
      chk("rd0_sof",   out_sof, 32'(k == 0));
      chk("rd0_eof",   out_eof, 32'(k == 7));
      chk("rd0_rd_en", rd_en,   1);
      tick();
    end
    #1;
    chk("rd0_back_to_fill", out_valid, 0);
    chk("rd0_frame_out",    frame_out, 1);
    tick();
    chk("rd0_frame_out_once", frame_out, 0);

    // Four back-to-back frames, both sides always ready
    out_ready = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      in_valid = (c < 32);
      din = 8'(c); #1;
      chk("cont_in_ready",  in_ready,  1);
      chk("cont_out_valid", out_valid, 32'((c >= 8) && (c < 40)));
      if ((c >= 8) && (c < 40)) begin
        chk("cont_data", dout, 32'(((c - 8) / 8) * 8 + int'(bitrev(AW'((c - 8) % 8)))));
        chk("cont_sof",  out_sof, 32'(((c - 8) % 8) == 0));
        chk("cont_eof",  out_eof, 32'(((c - 8) % 8) == 7));
      end
      tick();
    end
    in_valid = 1'b0;
`ifdef BRR_SCHED_STATS_EN
    chk("cont_no_stall", stall_cnt, 0);
    chk("cont_frames",   frame_cnt, 5);
`endif

    // Frame A (20..27) fills, frame B written with downstream stopped
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 8'(20 + i); tick();
    end
    for (int i = 0; i < 7; i++) begin
      din = 8'(30 + i); #1;
      chk("stl_in_ready", in_ready, 1);
      tick();
    end
    din = 8'd37; #1;
    chk("stl_ready_drop", in_ready,  0);
    chk("stl_out_valid",  out_valid, 1);
    tick();
    chk("stl_hold_ready", in_ready, 0);
    chk("stl_hold_wr_en", wr_en,    0);
    tick();
`ifdef BRR_SCHED_STATS_EN
    chk("stl_cnt_2", stall_cnt, 2);
`endif

    // Release downstream: last write lands with the last read of frame A
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("stl_rd_data",  dout,     32'(20 + int'(bitrev(AW'(k)))));
      chk("stl_rd_ready", in_ready, 32'(k == 7));
      chk("stl_rd_wr_en", wr_en,    32'(k == 7));
      tick();
    end
    in_valid = 1'b0; #1;
    chk("swap_valid",     out_valid, 1);
    chk("swap_data",      dout,      30);
    chk("swap_sof",       out_sof,   1);
    chk("swap_frame_in",  frame_in,  1);
    chk("swap_frame_out", frame_out, 1);
`ifdef BRR_SCHED_STATS_EN
    chk("swap_stall_cnt", stall_cnt, 9);
`endif

    // Drain frame B with no new input
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("b_rd_data", dout, 32'(30 + int'(bitrev(AW'(k)))));
      tick();
    end
    chk("b_fill_valid", out_valid, 0);
    chk("b_frame_out",  frame_out, 1);
    tick();
    chk("b_frame_out_once", frame_out, 0);
`ifdef BRR_SCHED_STATS_EN
    chk("b_frame_cnt", frame_cnt, 7);
`endif

    // Reset mid-frame while in DRAIN with wr_cnt=5
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      din = 8'(40 + i); tick();
    end
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("mid_rst_in_ready",  in_ready,  1);
    chk("mid_rst_out_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    chk("post_rst_stall", stall_cnt, 0);
    chk("post_rst_frame", frame_cnt, 0);

    // Fresh frame 60..67 must start from address 0
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 8'(60 + i); #1;
      chk("rf_out_valid", out_valid, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("rf_valid",   out_valid, 1);
    chk("rf_data0",   dout,      60);
    chk("rf_sof",     out_sof,   1);
    tick();
    chk("rf_data1",   dout,      64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
